ov5640_cfg_sequencer: RTL and testbench

Sequences the OV5640 register configuration after power-up. It waits for the power-on delay block to release the camera, then applies a settle interval. It then walks a 24-bit configuration ROM and issues one 16-bit-address/8-bit-data write per entry to the SCCB master over a valid/ready + done handshake. It supports in-table millisecond delays and an end marker, and reports cfg_done or cfg_error to the capture pipeline.

---
 rtl/ov5640_cfg_pkg.sv | 46 ++++
 rtl/ms_timer.sv | 61 ++++++
 rtl/ov5640_cfg_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_ov5640_cfg_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_cfg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ov5640_cfg_pkg
//  Description : Shared types and constants for the OV5640 configuration
//                sequencer: FSM state encoding, reserved ROM marker addresses,
//                ROM entry field widths and field slice helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ov5640_cfg_pkg;

    // ROM entry layout: {reg_addr[15:0], reg_data[7:0]}
    localparam int CFG_ENTRY_W    = 24;
    localparam int CFG_REG_ADDR_W = 16;
    localparam int CFG_REG_DATA_W = 8;

    // Width of the millisecond down-counter; wide enough for SETTLE_MS and
    // for the 8-bit in-table delay value.
    localparam int CFG_MS_W       = 16;

    // Reserved register addresses used as table control entries
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_END_ADDR   = 16'hFFFF;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_DELAY_ADDR = 16'hFFFE;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SETTLE   = 4'd1,
        ST_FETCH    = 4'd2,
        ST_DECODE   = 4'd3,
        ST_ISSUE    = 4'd4,
        ST_WAIT_ACK = 4'd5,
        ST_DELAY    = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } cfg_state_e;

    function automatic logic [CFG_REG_ADDR_W-1:0] entry_addr(input logic [CFG_ENTRY_W-1:0] e);
        return e[CFG_ENTRY_W-1:CFG_REG_DATA_W];
    endfunction

    function automatic logic [CFG_REG_DATA_W-1:0] entry_data(input logic [CFG_ENTRY_W-1:0] e);
        return e[CFG_REG_DATA_W-1:0];
    endfunction

endpackage : ov5640_cfg_pkg
`default_nettype wire

// File: rtl/ms_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ms_timer
//  Description : Millisecond down-counter with a CYCLES_PER_MS prescaler.
//                load_i starts a run of ms_i milliseconds; expired_o pulses
//                high for one cycle in the last cycle of the run, so a run of
//                N ms lasts exactly N*CYCLES_PER_MS cycles after the load.
//                Loading 0 leaves the timer idle (no expiry pulse).
//  Ports       : clk_i, rst_i (sync, active high), clear_i (abort run),
//                load_i / ms_i (start run), expired_o (one-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_timer
    import ov5640_cfg_pkg::*;
#(
    parameter int CYCLES_PER_MS = 27000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [CFG_MS_W-1:0] ms_i,
    output logic                expired_o
);

    localparam int               SUB_W    = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_MS - 1);

    logic                active_q;
    logic [CFG_MS_W-1:0] ms_q;
    logic [SUB_W-1:0]    sub_q;
    logic                w_ms_tick;

    assign w_ms_tick = active_q && (sub_q == SUB_LAST);
    assign expired_o = w_ms_tick && (ms_q == CFG_MS_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            active_q <= 1'b0;
            ms_q     <= '0;
            sub_q    <= '0;
        end else if (load_i) begin
            active_q <= (ms_i != '0);
            ms_q     <= ms_i;
            sub_q    <= '0;
        end else if (active_q) begin
            if (w_ms_tick) begin
                sub_q <= '0;
                ms_q  <= ms_q - CFG_MS_W'(1);
                if (ms_q == CFG_MS_W'(1)) begin
                    active_q <= 1'b0;
                end
            end else begin
                sub_q <= sub_q + SUB_W'(1);
            end
        end
    end

endmodule : ms_timer
`default_nettype wire

// File: rtl/ov5640_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ov5640_cfg_sequencer
//  Description : Walks the OV5640 configuration ROM after power-up and issues
//                one SCCB register write per entry. Entries with address FFFF
//                end the table, FFFE inserts a reg_data millisecond delay.
//                Optional macro CFG_RETRY_EN: re-issue a NACKed write up to
//                MAX_RETRY times before declaring an error.
//  Ports       : clk_27, rst (sync, active high), power_ready (level),
//                restart (pulse, honoured in DONE/ERROR only),
//                rom_addr / rom_data (1-cycle read latency),
//                sccb_valid/ready/addr/data (request), sccb_done/nack (result),
//                cfg_busy, cfg_done, cfg_error (status)
//  Revision    : 1.0 - initial release
// ============================================================================
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int CYCLES_PER_MS = 27000,
    parameter int SETTLE_MS     = 20,
    parameter int ROM_AW        = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic                   clk_27,
    input  logic                   rst,
    input  logic                   power_ready,
    input  logic                   restart,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [CFG_ENTRY_W-1:0] rom_data,
    output logic                   sccb_valid,
    input  logic                   sccb_ready,
    output logic [15:0]            sccb_addr,
    output logic [7:0]             sccb_data,
    input  logic                   sccb_done,
    input  logic                   sccb_nack,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    cfg_state_e          state_q, state_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                sccb_valid_q, sccb_valid_d;
    logic [15:0]         sccb_addr_q, sccb_addr_d;
    logic [7:0]          sccb_data_q, sccb_data_d;
    logic                cfg_done_q, cfg_done_d;
    logic                cfg_error_q, cfg_error_d;

    logic                w_tmr_load;
    logic                w_tmr_clear;
    logic [CFG_MS_W-1:0] w_tmr_ms;
    logic                w_tmr_expired;
    logic [15:0]         w_entry_addr;
    logic [7:0]          w_entry_data;
    logic                w_last_entry;

`ifdef CFG_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_q, retry_d;
`else
    logic w_unused_max_retry;
    assign w_unused_max_retry = (MAX_RETRY > 0);
`endif

    assign w_entry_addr = entry_addr(rom_data);
    assign w_entry_data = entry_data(rom_data);
    // Incrementing past the top address would wrap; treat it as an overrun.
    assign w_last_entry = (rom_addr_q == {ROM_AW{1'b1}});

    assign rom_addr   = rom_addr_q;
    assign sccb_valid = sccb_valid_q;
    assign sccb_addr  = sccb_addr_q;
    assign sccb_data  = sccb_data_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_error  = cfg_error_q;
    assign cfg_busy   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

    ms_timer #(
        .CYCLES_PER_MS (CYCLES_PER_MS)
    ) u_ms_timer (
        .clk_i     (clk_27),
        .rst_i     (rst),
        .clear_i   (w_tmr_clear),
        .load_i    (w_tmr_load),
        .ms_i      (w_tmr_ms),
        .expired_o (w_tmr_expired)
    );

    always_ff @(posedge clk_27) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            sccb_valid_q <= 1'b0;
            sccb_addr_q  <= '0;
            sccb_data_q  <= '0;
            cfg_done_q   <= 1'b0;
            cfg_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_valid_q <= sccb_valid_d;
            sccb_addr_q  <= sccb_addr_d;
            sccb_data_q  <= sccb_data_d;
            cfg_done_q   <= cfg_done_d;
            cfg_error_q  <= cfg_error_d;
        end
    end

`ifdef CFG_RETRY_EN
    always_ff @(posedge clk_27) begin
        if (rst) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_valid_d = sccb_valid_q;
        sccb_addr_d  = sccb_addr_q;
        sccb_data_d  = sccb_data_q;
        cfg_done_d   = cfg_done_q;
        cfg_error_d  = cfg_error_q;
        w_tmr_load   = 1'b0;
        w_tmr_clear  = 1'b0;
        w_tmr_ms     = '0;
`ifdef CFG_RETRY_EN
        retry_d      = retry_q;
`endif

        if ((state_q != ST_IDLE) && !power_ready) begin
            // Camera lost power: drop everything, abandon any SCCB request.
            state_d      = ST_IDLE;
            rom_addr_d   = '0;
            sccb_valid_d = 1'b0;
            sccb_addr_d  = '0;
            sccb_data_d  = '0;
            cfg_done_d   = 1'b0;
            cfg_error_d  = 1'b0;
            w_tmr_clear  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (power_ready) begin
                        rom_addr_d = '0;
                        if (SETTLE_MS == 0) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d    = ST_SETTLE;
                            w_tmr_load = 1'b1;
                            w_tmr_ms   = CFG_MS_W'(SETTLE_MS);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_expired) begin
                        state_d    = ST_FETCH;
                        rom_addr_d = '0;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_entry_addr == CFG_END_ADDR) begin
                        state_d    = ST_DONE;
                        cfg_done_d = 1'b1;
                    end else if (w_entry_addr == CFG_DELAY_ADDR) begin
                        if (w_last_entry) begin
                            state_d     = ST_ERROR;
                            cfg_error_d = 1'b1;
                        end else if (w_entry_data == 8'h00) begin
                            state_d    = ST_FETCH;
                            rom_addr_d = rom_addr_q + ROM_AW'(1);
                        end else begin
                            // Step the address now so the next entry is
                            // already on rom_data when the delay expires;
                            // DELAY then returns straight to DECODE.
                            state_d    = ST_DELAY;
                            rom_addr_d = rom_addr_q + ROM_AW'(1);
                            w_tmr_load = 1'b1;
                            w_tmr_ms   = {{(CFG_MS_W-8){1'b0}}, w_entry_data};
                        end
                    end else begin
                        state_d      = ST_ISSUE;
                        sccb_valid_d = 1'b1;
                        sccb_addr_d  = w_entry_addr;
                        sccb_data_d  = w_entry_data;
`ifdef CFG_RETRY_EN
                        retry_d      = '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (sccb_ready) begin
                        state_d      = ST_WAIT_ACK;
                        sccb_valid_d = 1'b0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sccb_done) begin
                        if (sccb_nack) begin
`ifdef CFG_RETRY_EN
                            if (retry_q != RETRY_W'(MAX_RETRY)) begin
                                state_d      = ST_ISSUE;
                                sccb_valid_d = 1'b1;
                                retry_d      = retry_q + RETRY_W'(1);
                            end else begin
                                state_d     = ST_ERROR;
                                cfg_error_d = 1'b1;
                            end
`else
                            state_d     = ST_ERROR;
                            cfg_error_d = 1'b1;
`endif
                        end else if (w_last_entry) begin
                            state_d     = ST_ERROR;
                            cfg_error_d = 1'b1;
                        end else begin
                            state_d    = ST_FETCH;
                            rom_addr_d = rom_addr_q + ROM_AW'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (w_tmr_expired) begin
                        state_d = ST_DECODE;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        state_d    = ST_FETCH;
                        cfg_done_d = 1'b0;
                        rom_addr_d = '0;
                    end
                end
                ST_ERROR: begin
                    sccb_valid_d = 1'b0;
                    if (restart) begin
                        state_d     = ST_FETCH;
                        cfg_error_d = 1'b0;
                        rom_addr_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule : ov5640_cfg_sequencer
`default_nettype wire

// File: tb/tb_ov5640_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ov5640_cfg_sequencer
//  Description : Directed self-checking bench for ov5640_cfg_sequencer with
//                CYCLES_PER_MS=10, SETTLE_MS=2, ROM_AW=2. The SCCB master model
//                raises ready one cycle after valid and pulses done five
//                cycles after the accept. Cycle numbers below are edge counts:
//                an input changed after edge c is first sampled at edge c+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_cfg_sequencer;

    localparam int CPM = 10;
    localparam int SMS = 2;
    localparam int AW  = 2;

    logic          clk_27 = 1'b0;
    logic          rst, power_ready, restart;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic          sccb_valid, sccb_ready, sccb_done, sccb_nack;
    logic [15:0]   sccb_addr;
    logic [7:0]    sccb_data;
    logic          cfg_busy, cfg_done, cfg_error;

    always #5 clk_27 = ~clk_27;

    ov5640_cfg_sequencer #(
        .CYCLES_PER_MS (CPM),
        .SETTLE_MS     (SMS),
        .ROM_AW        (AW),
        .MAX_RETRY     (3)
    ) dut (
        .clk_27      (clk_27),
        .rst         (rst),
        .power_ready (power_ready),
        .restart     (restart),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb_valid  (sccb_valid),
        .sccb_ready  (sccb_ready),
        .sccb_addr   (sccb_addr),
        .sccb_data   (sccb_data),
        .sccb_done   (sccb_done),
        .sccb_nack   (sccb_nack),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error)
    );

    // Configuration ROM with one cycle of read latency
    logic [23:0] rom [4];
    always @(posedge clk_27) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk_27) cyc <= cyc + 1;

    // ---------------- SCCB master model (acts on the falling edge) ----------
    int          n_acc = 0, n_done = 0, done_cnt = 0, stall = 0, done_edge = 0;
    logic [15:0] nack_mask = '0;
    logic        pend_nack = 1'b0, prev_valid = 1'b0, prev_pr = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    initial begin
        sccb_ready = 1'b0;
        sccb_done  = 1'b0;
        sccb_nack  = 1'b0;
        forever begin
            @(negedge clk_27);
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = pend_nack;
                    n_done++;
                    done_edge = cyc + 1;
                end
            end
            if (sccb_ready) begin
                if (prev_valid && prev_pr) begin
                    wr_addr.push_back(prev_addr);
                    wr_data.push_back(prev_data);
                    pend_nack = (n_acc < 16) ? nack_mask[n_acc] : 1'b0;
                    n_acc++;
                    done_cnt = 5;
                end
                sccb_ready = 1'b0;
            end else if (sccb_valid) begin
                if (stall > 0) stall--;
                else sccb_ready = 1'b1;
            end
            prev_valid = sccb_valid;
            prev_pr    = power_ready;
            prev_addr  = sccb_addr;
            prev_data  = sccb_data;
        end
    end

    // ---------------- checking helpers --------------------------------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_27);
        #3;
    endtask

    function automatic logic [23:0] wr_at(input int i);
        if (i < wr_addr.size()) return {wr_addr[i], wr_data[i]};
        return 24'hxxxxxx;
    endfunction

    task automatic clear_log();
        n_acc  = 0;
        n_done = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_rom(input logic [23:0] e0, e1, e2, e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sccb_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("valid_seen", (at >= 0), 1);
    endtask

    task automatic wait_flags(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((cfg_done | cfg_error) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("flag_seen", seen, 1);
    endtask

    task automatic wait_count(input bit use_done, input int n, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((use_done ? n_done : n_acc) >= n) begin
                seen = 1'b1;
                break;
            end
        end
        chk(use_done ? "done_seen" : "accept_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence -------------------------------------
    initial begin
        int at, t0, r, gap;
        rst         = 1'b1;
        power_ready = 1'b0;
        restart     = 1'b0;
        load_rom(24'h0, 24'h0, 24'h0, 24'h0);
        repeat (3) tick();

        chk("rst_valid",    sccb_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_addr_data", {sccb_addr, sccb_data}, 0);
        chk("rst_flags",    {cfg_busy, cfg_done, cfg_error}, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_power", {cfg_busy, sccb_valid}, 0);

        // Basic table: first valid 22 edges after power_ready is sampled
        load_rom(24'h300882, 24'h310303, 24'hFFFF00, 24'h000000);
        clear_log();
        power_ready = 1'b1;
        t0 = cyc + 1;
        wait_valid(100, at);
        chk("first_valid_latency", at - t0, 22);
        chk("first_write", {sccb_addr, sccb_data}, 24'h300882);
        chk("busy_in_issue", cfg_busy, 1);
        wait_flags(300);
        chk("basic_flags", {cfg_done, cfg_error, cfg_busy}, 3'b100);
        chk("basic_nwrites", n_acc, 2);
        chk("basic_wr0", wr_at(0), 24'h300882);
        chk("basic_wr1", wr_at(1), 24'h310303);

        // Delay entry of 5 ms = 50 cycles between 1st done and 2nd valid
        load_rom(24'h300882, 24'hFFFE05, 24'h300802, 24'hFFFF00);
        clear_log();
        pulse_restart();
        chk("restart_clears_done", {cfg_done, cfg_error, cfg_busy}, 3'b001);
        wait_count(1'b1, 1, 200);
        wait_valid(200, at);
        gap = at - done_edge;
        chk("delay_gap_50_to_53", (gap >= 50 && gap <= 53), 1);
        chk("delay_second_write", {sccb_addr, sccb_data}, 24'h300802);
        wait_flags(300);
        chk("delay_flags", {cfg_done, cfg_error}, 2'b10);
        chk("delay_nwrites", n_acc, 2);

        // Backpressure: ready withheld for 7 cycles
        load_rom(24'h300882, 24'h310303, 24'hFFFF00, 24'h000000);
        clear_log();
        stall = 7;
        pulse_restart();
        wait_valid(20, at);
        for (int i = 0; i < 7; i++) begin
            chk("bp_hold_stable", {sccb_valid, sccb_addr, sccb_data}, {1'b1, 24'h300882});
            tick();
        end
        wait_flags(300);
        chk("bp_single_accept", n_acc, 2);
        chk("bp_wr0", wr_at(0), 24'h300882);
        chk("bp_wr1", wr_at(1), 24'h310303);

`ifndef CFG_RETRY_EN
        // NACK on the 2nd write stops the table
        clear_log();
        nack_mask = 16'b0010;
        pulse_restart();
        wait_flags(300);
        chk("nack_flags", {cfg_done, cfg_error, cfg_busy}, 3'b010);
        chk("nack_nwrites", n_acc, 2);
        chk("nack_valid_low", sccb_valid, 0);
`else
        // Three NACKs then ACK on the 2nd entry still completes
        clear_log();
        nack_mask = 16'b01110;
        pulse_restart();
        wait_flags(400);
        chk("retry_ok_flags", {cfg_done, cfg_error}, 2'b10);
        chk("retry_ok_attempts", n_acc, 5);
        chk("retry_ok_wr4", wr_at(4), 24'h310303);
        // Four NACKs on the 2nd entry exhaust the retries
        clear_log();
        nack_mask = 16'b11110;
        pulse_restart();
        wait_flags(400);
        chk("retry_fail_flags", {cfg_done, cfg_error}, 2'b01);
        chk("retry_fail_attempts", n_acc, 5);
`endif
        nack_mask = '0;

        // No end marker in a 4-entry ROM; restart from ERROR skips SETTLE
        load_rom(24'h300001, 24'h300102, 24'h300203, 24'h300304);
        clear_log();
        pulse_restart();
        r = cyc;
        wait_valid(20, at);
        chk("restart_valid_latency", at - r, 2);
        wait_flags(400);
        chk("overrun_flags", {cfg_done, cfg_error}, 2'b01);
        chk("overrun_nwrites", n_acc, 4);
        chk("overrun_wr3", wr_at(3), 24'h300304);

        // Power loss while waiting for sccb_done
        load_rom(24'h300882, 24'h310303, 24'hFFFF00, 24'h000000);
        clear_log();
        pulse_restart();
        wait_count(1'b0, 1, 50);
        power_ready = 1'b0;
        tick();
        chk("drop_outputs_reset",
            {rom_addr, sccb_valid, sccb_addr, sccb_data, cfg_busy, cfg_done, cfg_error}, 0);
        repeat (10) tick();
        chk("drop_stale_done_ignored", {rom_addr, sccb_valid, cfg_busy, cfg_done}, 0);

        // Re-power: SETTLE again, restart during SETTLE has no effect
        clear_log();
        power_ready = 1'b1;
        t0 = cyc + 1;
        tick();
        pulse_restart();
        wait_valid(100, at);
        chk("repower_latency", at - t0, 22);
        chk("repower_entry0", {sccb_addr, sccb_data}, 24'h300882);
        wait_flags(300);
        chk("repower_flags", {cfg_done, cfg_error, cfg_busy}, 3'b100);
        chk("repower_nwrites", n_acc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ov5640_cfg_sequencer
`default_nettype wire
